conv_input_loader: RTL
======================

# conv_input_loader

Input-side control for the 1-D convolution engine. It is the writer that fills the X and F memories, which the convolution output controller later reads. It accepts the `x` and `f` AXI-stream-style input channels and generates write enables and write addresses for both memories. When both memories are full it asserts `conv_start` and holds it until the output controller pulses `conv_done`, then re-arms for the next vector/filter pair.

## Interface
Parameters:
- `X_MEM_SIZE`, default 8: number of X samples per convolution.
- `F_MEM_SIZE`, default 4: number of filter taps.
- `X_MEM_ADDR_WIDTH`, default 3: X memory address width; must be ≥ clog2(`X_MEM_SIZE`).
- `F_MEM_ADDR_WIDTH`, default 2: F memory address width; must be ≥ clog2(`F_MEM_SIZE`).

Ports:
- `clk`, in, 1: the single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `s_valid_x`, in, 1: X sample valid. Data goes from the datapath straight to the X memory.
- `s_ready_x`, out, 1: X channel ready.
- `s_valid_f`, in, 1: filter tap valid.
- `s_ready_f`, out, 1: F channel ready.
- `conv_done`, in, 1: one-cycle pulse from the output controller marking the end of convolution.
- `xmem_wr_en`, out, 1: X memory write enable.
- `xmem_wr_addr`, out, `X_MEM_ADDR_WIDTH`: X memory write address.
- `fmem_wr_en`, out, 1: F memory write enable.
- `fmem_wr_addr`, out, `F_MEM_ADDR_WIDTH`: F memory write address.
- `conv_start`, out, 1: both memories loaded; convolution may run.

## Operation
- Two independent per-channel FSMs, X and F, each with states LOAD and FULL, plus an address counter.
- Handshake: a transfer occurs when valid && ready are both high in the same cycle. Valid may arrive before ready. The block never waits on valid to assert ready.
- `s_ready_x` = (X state == LOAD). `s_ready_f` = (F state == LOAD). Both are derived from registered state, with no combinational path from valid.
- `xmem_wr_en` = `s_valid_x` && `s_ready_x`. The same rule applies to F.
- `xmem_wr_addr` = X counter. On each accept the counter increments.
- When an accept occurs with counter == `X_MEM_SIZE`-1:
  - the counter wraps to 0;
  - the state goes to FULL.
- F behaves identically with `F_MEM_SIZE`.
- The channels fill independently and in any interleaving. A full channel drops ready and waits for the other channel.
- `conv_start` = (X state == FULL) && (F state == FULL).
- On `conv_done` while `conv_start` is high:
  - both FSMs return to LOAD;
  - both counters clear to 0.
- `conv_done` while `conv_start` is low is ignored; state and counters are unchanged.
- No memory write ever occurs while `conv_start` is high, so memory contents are stable for the whole convolution.
- Reset values, with `reset` low asynchronously:
  - both states LOAD and both counters 0;
  - `s_ready_x` = `s_ready_f` = 1 and `conv_start` = 0;
  - `xmem_wr_en` = `fmem_wr_en` = 0 whenever valid is low.
- Reset asserted mid-load or mid-convolution discards all progress. The next load restarts at address 0.

## Timing
- Write latency is 0: address and enable are valid in the handshake cycle, and the memory captures on that rising edge.
- The last accept of the second channel to fill occurs in cycle N. Then, in cycle N+1:
  - `conv_start` = 1;
  - that channel's ready = 0.
- `conv_done` pulses in cycle M. Then, in cycle M+1:
  - `conv_start` = 0;
  - both readies = 1;
  - a new accept is possible.
- Minimum fill time is `X_MEM_SIZE` cycles if both channels stream continuously.
- Reset release: readies are high in the first cycle after `reset` deasserts.

## Structure
- Shared package `conv_pkg`:
  - `typedef enum logic {LOAD, FULL} load_state_t`;
  - a clog2-based localparam helper for address widths.
- One sub-module, `mem_load_ctrl`, parameterised by SIZE and ADDR_WIDTH. It contains one FSM, one counter, the ready and write-enable logic, and a `clear` input. The top instantiates it twice and adds the `conv_start` AND and the `conv_done` gating.

## Test plan
- Reset, then X valid held high with F idle:
  - X writes addresses 0..7 in 8 consecutive cycles;
  - `s_ready_x` = 0 from cycle 8;
  - `conv_start` stays 0.
- F valid held high after that:
  - F writes addresses 0..3;
  - `conv_start` = 1 one cycle after the F address-3 write;
  - no writes occur while `conv_start` is high, even with both valids held high.
- Valids toggle randomly, 50%:
  - addresses stay strictly sequential with no skips or duplicates;
  - `wr_en` is high only on handshake cycles.
- `conv_done` pulse while `conv_start` = 1:
  - next cycle `conv_start` = 0 and both readies = 1;
  - the following writes start at address 0.
- `conv_done` pulse during LOAD at X address 5: no effect, and the next X write goes to address 5.
- `reset` low for part of a cycle mid-convolution: `conv_start` drops immediately, and after release the reload starts at address 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution input side.
package conv_pkg;

   typedef enum logic {LOAD = 1'b0, FULL = 1'b1} load_state_t;

   // Address width needed to index a memory of the given depth (never below 1).
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int X_MEM_SIZE_DEF       = 8;
   localparam int F_MEM_SIZE_DEF       = 4;
   localparam int X_MEM_ADDR_WIDTH_DEF = addr_width(X_MEM_SIZE_DEF);
   localparam int F_MEM_ADDR_WIDTH_DEF = addr_width(F_MEM_SIZE_DEF);

endpackage

// File: rtl/mem_load_ctrl.sv
// One memory fill channel: LOAD/FULL FSM plus write address counter.
module mem_load_ctrl
   import conv_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic                  clear_i,
   output logic                  ready_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic                  full_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   load_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // Ready depends only on registered state, never on valid.
   assign ready_o   = (state_q == LOAD);
   assign wr_en_o   = valid_i && ready_o;
   assign wr_addr_o = cnt_q;
   assign full_o    = (state_q == FULL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         state_d = LOAD;
         cnt_d   = '0;
      end else if (wr_en_o) begin
         if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = FULL;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_input_loader.sv
// Fills the X and F memories and holds conv_start until the output side finishes.
module conv_input_loader
   import conv_pkg::*;
#(
   parameter int X_MEM_SIZE       = X_MEM_SIZE_DEF,
   parameter int F_MEM_SIZE       = F_MEM_SIZE_DEF,
   parameter int X_MEM_ADDR_WIDTH = X_MEM_ADDR_WIDTH_DEF,
   parameter int F_MEM_ADDR_WIDTH = F_MEM_ADDR_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_valid_x,
   output logic                        s_ready_x,
   input  logic                        s_valid_f,
   output logic                        s_ready_f,
   input  logic                        conv_done,
   output logic                        xmem_wr_en,
   output logic [X_MEM_ADDR_WIDTH-1:0] xmem_wr_addr,
   output logic                        fmem_wr_en,
   output logic [F_MEM_ADDR_WIDTH-1:0] fmem_wr_addr,
   output logic                        conv_start
);

   logic x_full, f_full;
   logic clear;

   // conv_done only counts while a convolution is actually running.
   assign conv_start = x_full && f_full;
   assign clear      = conv_done && conv_start;

   mem_load_ctrl #(
      .SIZE       (X_MEM_SIZE),
      .ADDR_WIDTH (X_MEM_ADDR_WIDTH)
   ) u_x_ctrl (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (s_valid_x),
      .clear_i   (clear),
      .ready_o   (s_ready_x),
      .wr_en_o   (xmem_wr_en),
      .wr_addr_o (xmem_wr_addr),
      .full_o    (x_full)
   );

   mem_load_ctrl #(
      .SIZE       (F_MEM_SIZE),
      .ADDR_WIDTH (F_MEM_ADDR_WIDTH)
   ) u_f_ctrl (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (s_valid_f),
      .clear_i   (clear),
      .ready_o   (s_ready_f),
      .wr_en_o   (fmem_wr_en),
      .wr_addr_o (fmem_wr_addr),
      .full_o    (f_full)
   );

endmodule
